// File: rtl/flex_counter_ext.sv
// Up/down counter with clear, load and a programmable terminal value.
// Optional saturation mode is enabled by FLEX_COUNTER_EXT_SATURATE_EN.
module flex_counter_ext #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             down,
  input  logic [WIDTH-1:0] rollover_val,
`ifdef FLEX_COUNTER_EXT_SATURATE_EN
  input  logic             sat_mode,
`endif
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag,
  output logic             wrap_pulse
);

  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             next_flag;
  logic             sat_on;

  always_comb begin
`ifdef FLEX_COUNTER_EXT_SATURATE_EN
    sat_on = sat_mode;
`else
    sat_on = 1'b0;
`endif
  end

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (clear) begin
      next_count = '0;
    end else if (load) begin
      next_count = load_val;
    end else if (enable) begin
      if (!down) begin
        if (count >= rollover_val) begin
          if (sat_on) begin
            next_count = rollover_val;
          end else begin
            next_count = '0;
            next_wrap  = 1'b1;
          end
        end else begin
          next_count = count + 1'b1;
        end
      end else begin
        if (count == '0 || count > rollover_val) begin
          // Saturating down: hold at 0, but still pull an
          // out-of-range count back into range without a pulse.
          if (sat_on) begin
            next_count = (count == '0) ? '0 : rollover_val;
          end else begin
            next_count = rollover_val;
            next_wrap  = 1'b1;
          end
        end else begin
          next_count = count - 1'b1;
        end
      end
    end
  end

  // Flag tracks the value count will hold after this edge.
  always_comb begin
    next_flag = down ? (next_count == '0)
                     : (next_count == rollover_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      wrap_pulse    <= 1'b0;
      rollover_flag <= down || (rollover_val == '0);
    end else begin
      count         <= next_count;
      wrap_pulse    <= next_wrap;
      rollover_flag <= next_flag;
    end
  end

endmodule

// File: tb/tb_flex_counter_ext.sv
// Directed self-checking bench for flex_counter_ext.
// Exercises FLEX_COUNTER_EXT_SATURATE_EN when that macro is defined.
module tb_flex_counter_ext;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         enable;
  logic         down;
  logic [W-1:0] rollover_val;
`ifdef FLEX_COUNTER_EXT_SATURATE_EN
  logic         sat_mode;
`endif
  logic [W-1:0] count;
  logic         rollover_flag;
  logic         wrap_pulse;

  int n_run  = 0;
  int n_fail = 0;

  flex_counter_ext #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .enable       (enable),
    .down         (down),
    .rollover_val (rollover_val),
`ifdef FLEX_COUNTER_EXT_SATURATE_EN
    .sat_mode     (sat_mode),
`endif
    .count        (count),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag,
                      input logic [31:0] c,
                      input logic w,
                      input logic f);
    check({tag, ".count"}, 32'(count), c);
    check({tag, ".wrap"}, 32'(wrap_pulse), 32'(w));
    check({tag, ".flag"}, 32'(rollover_flag), 32'(f));
  endtask

  int dn_c[7] = '{5, 4, 3, 2, 1, 0, 5};
  bit dn_w[7] = '{1, 0, 0, 0, 0, 0, 1};
  bit dn_f[7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    rst = 1; clear = 0; load = 0; load_val = '0;
    enable = 0; down = 0; rollover_val = 16'd9;
`ifdef FLEX_COUNTER_EXT_SATURATE_EN
    sat_mode = 0;
`endif
    step(); step();
    chk3("reset", 0, 0, 0);

    // up count 0..9 repeating
    rst = 0; enable = 1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk3($sformatf("up%0d", k), k % 10,
           (k % 10) == 0, (k % 10) == 9);
    end

    // clear with down=1: flag reflects down-terminal 0
    clear = 1; down = 1; rollover_val = 16'd5;
    step();
    chk3("clr_dn", 0, 0, 1);
    clear = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk3($sformatf("dn%0d", i), dn_c[i], dn_w[i], dn_f[i]);
    end

    // load beats enable, out-of-range load wraps next
    down = 0; rollover_val = 16'd9;
    load = 1; load_val = 16'd12;
    step();
    chk3("ld12", 12, 0, 0);
    load = 0;
    step();
    chk3("ld12_wrap", 0, 1, 0);

    // clear beats load and enable
    load = 1; load_val = 16'd7; enable = 0;
    step();
    check("ld7", 32'(count), 7);
    clear = 1; load = 1; enable = 1;
    step();
    chk3("clr_ld_en", 0, 0, 0);

    // clear in a would-wrap cycle suppresses pulse
    clear = 0; load = 1; load_val = 16'd9; enable = 0;
    step();
    chk3("ld9", 9, 0, 1);
    load = 0; clear = 1; enable = 1;
    step();
    chk3("clr_at_wrap", 0, 0, 0);

    // rst beats clear
    clear = 0; load = 1; load_val = 16'd3; enable = 0;
    step();
    check("ld3", 32'(count), 3);
    load = 0; rst = 1; clear = 1; enable = 1;
    step();
    chk3("rst_clr", 0, 0, 0);
    rst = 0; clear = 0;
    step();
    chk3("resume", 1, 0, 0);

    // hold with nothing active
    enable = 0;
    step();
    chk3("hold", 1, 0, 0);

    // full range
    rollover_val = 16'hFFFF; load = 1; load_val = 16'hFFFE;
    step();
    load = 0; enable = 1;
    step();
    chk3("fr0", 32'hFFFF, 0, 1);
    step();
    chk3("fr1", 0, 1, 0);
    step();
    chk3("fr2", 1, 0, 0);

    // rollover_val = 0, both directions
    rollover_val = '0;
    step();
    chk3("rv0_up_a", 0, 1, 1);
    step();
    chk3("rv0_up_b", 0, 1, 1);
    down = 1;
    step();
    chk3("rv0_dn", 0, 1, 1);

    // down with count above rollover_val
    rollover_val = 16'd9; load = 1; load_val = 16'd12;
    step();
    chk3("ld12_dn", 12, 0, 0);
    load = 0;
    step();
    chk3("dn_over", 9, 1, 0);
    step();
    chk3("dn_8", 8, 0, 0);

    // rst mid-count with down=1 sets flag
    rst = 1;
    step();
    chk3("rst_dn", 0, 0, 1);
    rst = 0;

`ifdef FLEX_COUNTER_EXT_SATURATE_EN
    down = 0; rollover_val = 16'd3; sat_mode = 1;
    clear = 1;
    step();
    clear = 0; enable = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("sat%0d.count", i), 32'(count),
            (i < 3) ? i + 1 : 3);
      check($sformatf("sat%0d.wrap", i), 32'(wrap_pulse), 0);
    end
    down = 1; clear = 1;
    step();
    clear = 0;
    step();
    check("sat_dn.count", 32'(count), 0);
    check("sat_dn.wrap", 32'(wrap_pulse), 0);
    sat_mode = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/flex_counter_ext.md
FLEX_COUNTER_EXT -- requirements
Module: flex_counter_ext

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning counter, rollover value and load value width in bits (legal 2..32).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port clear  input  1  synchronous clear of count to 0.
REQ-005 The block SHALL have port load  input  1  synchronous load of load_val into count.
REQ-006 The block SHALL have port load_val  input  WIDTH  value loaded when load=1.
REQ-007 The block SHALL have port enable  input  1  count one step per cycle while high.
REQ-008 The block SHALL have port down  input  1  direction: 0 = count up, 1 = count down.
REQ-009 The block SHALL have port rollover_val  input  WIDTH  terminal value; count range is 0..rollover_val.
REQ-010 The block SHALL have port count  output  WIDTH  current count, registered.
REQ-011 The block SHALL have port rollover_flag  output  1  registered terminal-count flag.
REQ-012 The block SHALL have port wrap_pulse  output  1  registered one-cycle pulse marking a wrap.

Function
REQ-013 The block SHALL apply per-edge priority rst > clear > load > enable; with none active, count SHALL hold.
REQ-014 With enable=1 and down=0, count SHALL go to count+1, or to 0 if count >= rollover_val.
REQ-015 With enable=1 and down=1, count SHALL go to count-1, or to rollover_val if count == 0 or count > rollover_val.
REQ-016 wrap_pulse SHALL be 1 for exactly the cycle after an enabled step that wrapped (REQ-014/015 wrap branch); otherwise 0.
REQ-017 rollover_flag SHALL be 1 whenever the registered count equals rollover_val (down=0) or equals 0 (down=1), evaluated on the next-state value so it aligns with count; otherwise 0.
REQ-018 A load of load_val > rollover_val SHALL be accepted; the next enabled step SHALL wrap per REQ-014/015.
REQ-019 rollover_val = 0 SHALL keep count at 0 with rollover_flag=1 and wrap_pulse=1 on every enabled cycle.
REQ-020 Changes to down or rollover_val SHALL take effect on the next edge with no pipeline delay; latency from any control input to count SHALL be one cycle.
REQ-021 All arithmetic SHALL be unsigned modulo 2^WIDTH; rollover_val = 2^WIDTH-1 SHALL give full-range counting.
REQ-022 clear or load in a wrap cycle SHALL suppress wrap_pulse.

Reset
REQ-023 On rst=1 at a rising edge, count SHALL become 0, wrap_pulse 0, and rollover_flag (down==1 || rollover_val==0) on the following cycle.
REQ-024 rst asserted mid-count SHALL override all other inputs on that edge; counting SHALL resume from 0 on the first edge after rst deasserts.

Configuration
REQ-025 With macro FLEX_COUNTER_EXT_SATURATE_EN defined, an input port sat_mode (1 bit) SHALL exist; when sat_mode=1, an enabled step at the terminal value SHALL hold count (at rollover_val up, at 0 down) and wrap_pulse SHALL stay 0.
REQ-026 Without FLEX_COUNTER_EXT_SATURATE_EN, sat_mode SHALL be absent and behaviour SHALL be always-wrap per REQ-014/015.

Verification
REQ-027 WIDTH=16, rst 2 cycles, enable=1, down=0, rollover_val=9 for 32 cycles -> count 0..9 repeating, wrap_pulse 1 on cycles after each 9->0, rollover_flag 1 while count=9.
REQ-028 down=1, rollover_val=5, from count 0 -> count 5,4,3,2,1,0,5; wrap_pulse after each 0->5; rollover_flag 1 at count 0.
REQ-029 load=1 with load_val=12 and enable=1, rollover_val=9 -> count 12 next cycle (load wins), then 0 with wrap_pulse=1.
REQ-030 clear, load and enable all 1 at count 7 -> count 0, wrap_pulse 0; rst with clear at count 3 -> count 0.
REQ-031 rollover_val=16'hFFFF, load 16'hFFFE, enable up 3 cycles -> FFFF, 0000 (wrap_pulse=1), 0001.
REQ-032 With FLEX_COUNTER_EXT_SATURATE_EN, sat_mode=1, rollover_val=3, enable up 6 cycles -> 1,2,3,3,3,3, wrap_pulse never 1.
